// File: rtl/riscv_pkg.sv
// Shared RISC-V types for the MA-stage atomic sequencer.
//   amo_state_e  : AMO read-modify-write sequencer states
//   amo_funct5_e : funct5 field encodings of the RV32A instructions
package riscv_pkg;

    typedef enum logic [1:0] {
        AMO_IDLE  = 2'd0,
        AMO_READ  = 2'd1,
        AMO_WRITE = 2'd2,
        AMO_DONE  = 2'd3
    } amo_state_e;

    typedef enum logic [4:0] {
        AMO_ADD  = 5'b00000,
        AMO_SWAP = 5'b00001,
        AMO_LR   = 5'b00010,
        AMO_SC   = 5'b00011,
        AMO_XOR  = 5'b00100,
        AMO_OR   = 5'b01000,
        AMO_AND  = 5'b01100,
        AMO_MIN  = 5'b10000,
        AMO_MAX  = 5'b10100,
        AMO_MINU = 5'b11000,
        AMO_MAXU = 5'b11100
    } amo_funct5_e;

endpackage

// File: rtl/amo_alu.sv
// Combinational AMO operation unit.
//   old_val : value read from memory
//   rs2     : rs2 operand
//   funct5  : AMO opcode
//   result  : new memory value (old_val for codes that are not AMO ops)
module amo_alu import riscv_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] rs2,
    input  amo_funct5_e     funct5,
    output logic [XLEN-1:0] result
);

    logic lt_s;
    logic lt_u;

    assign lt_s = $signed(old_val) < $signed(rs2);
    assign lt_u = old_val < rs2;

    always_comb begin
        result = old_val;
        case (funct5)
            AMO_SWAP: result = rs2;
            AMO_ADD:  result = old_val + rs2;
            AMO_XOR:  result = old_val ^ rs2;
            AMO_AND:  result = old_val & rs2;
            AMO_OR:   result = old_val | rs2;
            AMO_MIN:  result = lt_s ? old_val : rs2;
            AMO_MAX:  result = lt_s ? rs2 : old_val;
            AMO_MINU: result = lt_u ? old_val : rs2;
            AMO_MAXU: result = lt_u ? rs2 : old_val;
            default:  result = old_val;
        endcase
    end

endmodule

// File: rtl/amo_unit.sv
// MA-stage sequencer for RV32A: AMO read-modify-write and LR/SC reservation.
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_amo_valid              : AMO (not LR/SC) in MA
//   i_lr_valid, i_sc_valid   : LR.W / SC.W in MA (first cycle only)
//   i_amo_funct5, i_addr,
//   i_rs2_data               : instruction operands
//   i_mem_read_data          : memory data, one cycle after i_addr
//   i_pipe_stall_ext, i_flush: pipeline control
//   i_store_snoop_*          : committed stores, used to break reservations
//   o_stall                  : AMO stall request
//   o_amo_read_phase         : memory data valid for the AMO
//   o_amo_write_enable, o_amo_addr, o_amo_result : AMO write port
//   o_rd_data                : old memory value for rd
//   o_sc_success             : SC.W outcome (same cycle as i_sc_valid)
//   o_reservation_valid      : reservation held
module amo_unit import riscv_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_amo_valid,
    input  logic            i_lr_valid,
    input  logic            i_sc_valid,
    input  logic [4:0]      i_amo_funct5,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [XLEN-1:0] i_mem_read_data,
    input  logic            i_pipe_stall_ext,
    input  logic            i_flush,
    input  logic            i_store_snoop_valid,
    input  logic [XLEN-1:0] i_store_snoop_addr,
    output logic            o_stall,
    output logic            o_amo_read_phase,
    output logic            o_amo_write_enable,
    output logic [XLEN-1:0] o_amo_addr,
    output logic [XLEN-1:0] o_amo_result,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_sc_success,
    output logic            o_reservation_valid
);

    amo_state_e      state_q, state_d;
    amo_funct5_e     funct5_q;
    logic [XLEN-1:0] addr_q, rs2_q, old_q, result_q, alu_result;
    logic            res_valid_q;
    logic [XLEN-3:0] res_addr_q;
    logic            accept, snoop_hit;
    logic            unused_addr_bits;

    // Byte offset is irrelevant for word atomics and reservations.
    assign unused_addr_bits = ^{i_addr[1:0], i_store_snoop_addr[1:0]};

    assign accept = (state_q == AMO_IDLE) && i_amo_valid && !i_flush;

    always_comb begin
        state_d            = state_q;
        o_stall            = 1'b0;
        o_amo_read_phase   = 1'b0;
        o_amo_write_enable = 1'b0;
        case (state_q)
            AMO_IDLE: begin
                if (accept) begin
                    o_stall = 1'b1;
                    state_d = AMO_READ;
                end
            end
            AMO_READ: begin
                o_stall          = 1'b1;
                o_amo_read_phase = 1'b1;
                state_d          = i_flush ? AMO_IDLE : AMO_WRITE;
            end
            // The write commits regardless of flush.
            AMO_WRITE: begin
                o_amo_write_enable = 1'b1;
                state_d            = i_pipe_stall_ext ? AMO_DONE : AMO_IDLE;
            end
            // Instruction still held in MA: block re-triggering it.
            AMO_DONE: begin
                if (!i_pipe_stall_ext || i_flush)
                    state_d = AMO_IDLE;
            end
            default: state_d = AMO_IDLE;
        endcase
    end

    amo_alu #(.XLEN(XLEN)) u_alu (
        .old_val (i_mem_read_data),
        .rs2     (rs2_q),
        .funct5  (funct5_q),
        .result  (alu_result)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= AMO_IDLE;
            funct5_q <= AMO_ADD;
            addr_q   <= '0;
            rs2_q    <= '0;
            old_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= {i_addr[XLEN-1:2], 2'b00};
                rs2_q    <= i_rs2_data;
                funct5_q <= amo_funct5_e'(i_amo_funct5);
            end
            if (state_q == AMO_READ && !i_flush) begin
                old_q    <= i_mem_read_data;
                result_q <= alu_result;
            end
        end
    end

    assign snoop_hit = i_store_snoop_valid && res_valid_q &&
                       (i_store_snoop_addr[XLEN-1:2] == res_addr_q);

    // LR takes priority over a same-cycle snoop; any SC consumes the reservation.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
        end else if (i_lr_valid) begin
            res_valid_q <= 1'b1;
            res_addr_q  <= i_addr[XLEN-1:2];
        end else if (i_sc_valid || snoop_hit) begin
            res_valid_q <= 1'b0;
        end
    end

    assign o_sc_success        = i_sc_valid && res_valid_q && (i_addr[XLEN-1:2] == res_addr_q);
    assign o_reservation_valid = res_valid_q;
    assign o_amo_addr          = addr_q;
    assign o_amo_result        = result_q;
    assign o_rd_data           = old_q;

endmodule

// File: tb/tb_amo_unit.sv
// Self-checking bench for amo_unit: directed scenarios plus randomized AMOs
// checked against a word-array memory model with spec-level op semantics.
module tb_amo_unit;

    logic        i_clk = 1'b0;
    logic        i_rst, i_amo_valid, i_lr_valid, i_sc_valid;
    logic [4:0]  i_amo_funct5;
    logic [31:0] i_addr, i_rs2_data, i_mem_read_data;
    logic        i_pipe_stall_ext, i_flush, i_store_snoop_valid;
    logic [31:0] i_store_snoop_addr;
    logic        o_stall, o_amo_read_phase, o_amo_write_enable;
    logic [31:0] o_amo_addr, o_amo_result, o_rd_data;
    logic        o_sc_success, o_reservation_valid;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int exp_wr = 0;
    int cyc    = 0;
    int wr_cyc [$];

    // Environment memory: 1-cycle read latency, written by the DUT.
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic        tb_clr, poke_en;
    logic [7:0]  poke_idx;
    logic [31:0] poke_data;

    localparam logic [4:0] CODES [9] = '{5'b00001, 5'b00000, 5'b00100, 5'b01100,
                                         5'b01000, 5'b10000, 5'b10100, 5'b11000, 5'b11100};

    always #5 i_clk = ~i_clk;

    amo_unit #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_amo_valid(i_amo_valid),
        .i_lr_valid(i_lr_valid), .i_sc_valid(i_sc_valid), .i_amo_funct5(i_amo_funct5),
        .i_addr(i_addr), .i_rs2_data(i_rs2_data), .i_mem_read_data(i_mem_read_data),
        .i_pipe_stall_ext(i_pipe_stall_ext), .i_flush(i_flush),
        .i_store_snoop_valid(i_store_snoop_valid), .i_store_snoop_addr(i_store_snoop_addr),
        .o_stall(o_stall), .o_amo_read_phase(o_amo_read_phase),
        .o_amo_write_enable(o_amo_write_enable), .o_amo_addr(o_amo_addr),
        .o_amo_result(o_amo_result), .o_rd_data(o_rd_data),
        .o_sc_success(o_sc_success), .o_reservation_valid(o_reservation_valid)
    );

    always @(posedge i_clk) begin
        i_mem_read_data <= mem[i_addr[9:2]];
        if (tb_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (poke_en) begin
            mem[poke_idx] <= poke_data;
        end else if (o_amo_write_enable) begin
            mem[o_amo_addr[9:2]] <= o_amo_result;
        end
    end

    always @(negedge i_clk) begin
        cyc++;
        if (o_amo_write_enable) begin
            wr_cnt++;
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (f)
            5'b00001: return b;
            5'b00000: return a + b;
            5'b00100: return a ^ b;
            5'b01100: return a & b;
            5'b01000: return a | b;
            5'b10000: return (sa <= sb) ? a : b;
            5'b10100: return (sa >= sb) ? a : b;
            5'b11000: return (a <= b) ? a : b;
            5'b11100: return (a >= b) ? a : b;
            default:  return a;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        poke_en   = 1'b1;
        poke_idx  = addr[9:2];
        poke_data = data;
        ref_mem[addr[9:2]] = data;
        @(negedge i_clk);
        poke_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(o_stall), 32'h0);
        chk({tag, "_rphase"}, 32'(o_amo_read_phase), 32'h0);
        chk({tag, "_we"}, 32'(o_amo_write_enable), 32'h0);
        chk({tag, "_addr"}, o_amo_addr, 32'h0);
        chk({tag, "_result"}, o_amo_result, 32'h0);
        chk({tag, "_rd"}, o_rd_data, 32'h0);
        chk({tag, "_scok"}, 32'(o_sc_success), 32'h0);
        chk({tag, "_resv"}, 32'(o_reservation_valid), 32'h0);
    endtask

    // Called at a negedge; returns at the negedge after the instruction leaves MA.
    task automatic amo_op(input string tag, input logic [4:0] f5, input logic [31:0] addr,
                          input logic [31:0] rs2, input int ext_cycles);
        logic [31:0] old, exp;
        old = ref_mem[addr[9:2]];
        exp = ref_op(f5, old, rs2);
        ref_mem[addr[9:2]] = exp;
        exp_wr++;
        i_amo_valid = 1'b1; i_amo_funct5 = f5; i_addr = addr; i_rs2_data = rs2;
        #1;
        chk({tag, "_acc_stall"}, 32'(o_stall), 32'h1);
        chk({tag, "_acc_rphase"}, 32'(o_amo_read_phase), 32'h0);
        chk({tag, "_acc_we"}, 32'(o_amo_write_enable), 32'h0);
        @(negedge i_clk); #1;
        chk({tag, "_rd_stall"}, 32'(o_stall), 32'h1);
        chk({tag, "_rd_rphase"}, 32'(o_amo_read_phase), 32'h1);
        chk({tag, "_rd_we"}, 32'(o_amo_write_enable), 32'h0);
        @(negedge i_clk);
        if (ext_cycles > 0) i_pipe_stall_ext = 1'b1;
        #1;
        chk({tag, "_wr_we"}, 32'(o_amo_write_enable), 32'h1);
        chk({tag, "_wr_stall"}, 32'(o_stall), 32'h0);
        chk({tag, "_wr_addr"}, o_amo_addr, {addr[31:2], 2'b00});
        chk({tag, "_wr_result"}, o_amo_result, exp);
        chk({tag, "_wr_rd"}, o_rd_data, old);
        for (int k = 1; k < ext_cycles; k++) begin
            @(negedge i_clk); #1;
            chk({tag, "_done_we"}, 32'(o_amo_write_enable), 32'h0);
            chk({tag, "_done_stall"}, 32'(o_stall), 32'h0);
        end
        if (ext_cycles > 0) begin
            @(negedge i_clk);
            i_pipe_stall_ext = 1'b0;
            #1;
            chk({tag, "_rel_we"}, 32'(o_amo_write_enable), 32'h0);
            chk({tag, "_rel_stall"}, 32'(o_stall), 32'h0);
        end
        @(negedge i_clk);
        i_amo_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [4:0]  f5;
        logic [31:0] a, r;

        i_rst = 1'b1; tb_clr = 1'b1; poke_en = 1'b0; poke_idx = '0; poke_data = '0;
        i_amo_valid = 0; i_lr_valid = 0; i_sc_valid = 0; i_amo_funct5 = '0;
        i_addr = '0; i_rs2_data = '0; i_pipe_stall_ext = 0; i_flush = 0;
        i_store_snoop_valid = 0; i_store_snoop_addr = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0; tb_clr = 1'b0;
        #1;
        chk_all_zero("reset");
        @(negedge i_clk);

        // AMOADD overflow wrap
        poke(32'h100, 32'h7FFFFFFF);
        amo_op("amoadd", 5'b00000, 32'h100, 32'h1, 0);
        #1 chk("amoadd_lit_mem", mem[8'h40], 32'h80000000);

        // signed vs unsigned min
        poke(32'h104, 32'hFFFFFFFE);
        amo_op("amomin", 5'b10000, 32'h104, 32'h3, 0);
        poke(32'h104, 32'hFFFFFFFE);
        amo_op("amominu", 5'b11000, 32'h107, 32'h3, 0);
        #1 chk("amominu_lit_mem", mem[8'h41], 32'h3);

        // external stall held 3 cycles starting at WRITE
        poke(32'h108, 32'h0000_00F0);
        amo_op("extstall", 5'b01000, 32'h108, 32'h0000_000F, 3);
        #1 chk("extstall_writes", wr_cnt, exp_wr);

        // flush during READ: no write, back to IDLE
        i_amo_valid = 1; i_amo_funct5 = 5'b00001; i_addr = 32'h10C; i_rs2_data = 32'hDEAD;
        @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0; i_amo_valid = 1'b0;
        #1;
        chk("flush_we", 32'(o_amo_write_enable), 32'h0);
        chk("flush_stall", 32'(o_stall), 32'h0);
        chk("flush_rphase", 32'(o_amo_read_phase), 32'h0);
        @(negedge i_clk); #1;
        chk("flush_writes", wr_cnt, exp_wr);
        @(negedge i_clk);

        // LR then SC to same word
        i_lr_valid = 1; i_addr = 32'h200;
        @(negedge i_clk);
        i_lr_valid = 0; i_sc_valid = 1;
        #1;
        chk("lrsc_resv", 32'(o_reservation_valid), 32'h1);
        chk("lrsc_ok", 32'(o_sc_success), 32'h1);
        @(negedge i_clk);
        i_sc_valid = 0;
        #1 chk("lrsc_cleared", 32'(o_reservation_valid), 32'h0);
        // LR, snoop to same word (other byte), SC fails
        i_lr_valid = 1; i_addr = 32'h200;
        @(negedge i_clk);
        i_lr_valid = 0; i_store_snoop_valid = 1; i_store_snoop_addr = 32'h202;
        @(negedge i_clk);
        i_store_snoop_valid = 0; i_sc_valid = 1; i_addr = 32'h200;
        #1;
        chk("snoop_resv", 32'(o_reservation_valid), 32'h0);
        chk("snoop_scfail", 32'(o_sc_success), 32'h0);
        @(negedge i_clk);
        i_sc_valid = 0;
        // LR wins over same-cycle matching snoop; SC to other word fails and clears
        i_lr_valid = 1; i_addr = 32'h300; i_store_snoop_valid = 1; i_store_snoop_addr = 32'h300;
        @(negedge i_clk);
        i_lr_valid = 0; i_store_snoop_valid = 0; i_sc_valid = 1; i_addr = 32'h304;
        #1;
        chk("lrwin_resv", 32'(o_reservation_valid), 32'h1);
        chk("sc_other_fail", 32'(o_sc_success), 32'h0);
        @(negedge i_clk);
        i_sc_valid = 0;
        #1 chk("sc_fail_cleared", 32'(o_reservation_valid), 32'h0);

        // reset during READ, with a reservation held
        i_lr_valid = 1; i_addr = 32'h300;
        @(negedge i_clk);
        i_lr_valid = 0;
        i_amo_valid = 1; i_amo_funct5 = 5'b00000; i_addr = 32'h100; i_rs2_data = 32'h5;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0; i_amo_valid = 1'b0;
        #1;
        chk_all_zero("rst_read");
        chk("rst_read_writes", wr_cnt, exp_wr);
        @(negedge i_clk);

        // back-to-back AMOSWAP then AMOOR
        n = wr_cyc.size();
        amo_op("b2b_swap", 5'b00001, 32'h110, 32'h0000_1200, 0);
        amo_op("b2b_or", 5'b01000, 32'h110, 32'h0000_0034, 0);
        #1;
        chk("b2b_count", wr_cyc.size() - n, 2);
        if (wr_cyc.size() - n == 2) chk("b2b_spacing", wr_cyc[n+1] - wr_cyc[n], 3);
        chk("b2b_lit_mem", mem[8'h44], 32'h0000_1234);
        @(negedge i_clk);

        // randomized AMOs against the memory model
        for (int t = 0; t < 40; t++) begin
            f5 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : CODES[$urandom_range(0, 8)];
            a  = $urandom & 32'h0000_003F;
            r  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 4)) - 32'd2;
            amo_op("rand", f5, a, r, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end

        #1 chk("total_writes", wr_cnt, exp_wr);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/amo_unit.md
# amo_unit

Sequencer for RV32A atomics in the MA stage: runs the read-modify-write for AMO instructions and keeps the LR/SC reservation. It feeds the forwarding unit's AMO inputs (`o_amo_read_phase`, `o_amo_write_enable`, `o_amo_result`) and the stall path in `pipeline_ctrl`. Data memory is single-port with 1-cycle read latency. The address is presented by the EX→MA register, so read data for an MA instruction arrives in the cycle after it enters MA.

## Interface
- `XLEN`, 32, datapath width.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_amo_valid`  in  1  AMO instruction (not LR/SC) occupies MA.
- `i_lr_valid` / `i_sc_valid`  in  1  LR.W / SC.W occupies MA (first cycle only).
- `i_amo_funct5`  in  5  AMO opcode, funct5 field.
- `i_addr`  in  XLEN  data address; bits [1:0] ignored.
- `i_rs2_data`  in  XLEN  rs2 operand.
- `i_mem_read_data`  in  XLEN  memory read data.
- `i_pipe_stall_ext`  in  1  stall from any other source.
- `i_flush`  in  1  kill the MA instruction.
- `i_store_snoop_valid`, `i_store_snoop_addr`  in  1, XLEN  committed store or AMO write from any source.
- `o_stall`  out  1  AMO stall request.
- `o_amo_read_phase`  out  1  memory data valid for an AMO.
- `o_amo_write_enable`  out  1  write `o_amo_result` to `o_amo_addr`.
- `o_amo_addr`  out  XLEN  word-aligned AMO address.
- `o_amo_result`  out  XLEN  new memory value.
- `o_rd_data`  out  XLEN  old memory value destined for rd.
- `o_sc_success`  out  1  SC.W succeeds (combinational, same cycle as `i_sc_valid`).
- `o_reservation_valid`  out  1  reservation held.

## Operation
- **States:** IDLE, READ, WRITE, DONE.
- **IDLE**
  - On `i_amo_valid && !i_flush`: `o_stall`=1 (combinational); latch address, rs2 and funct5; next state READ.
  - On `i_flush`: stay in IDLE.
- **READ**
  - `o_stall`=1 and `o_amo_read_phase`=1.
  - Capture `i_mem_read_data` into `old_q`; compute `result_q` = op(`old_q`, rs2); next state WRITE.
  - `i_flush` here returns to IDLE with no write.
- **WRITE**
  - `o_amo_write_enable`=1 for exactly one cycle; `o_stall`=0; `o_rd_data`=`old_q`. Flush is ignored because the write commits.
  - Next state DONE if `i_pipe_stall_ext`, else IDLE.
- **DONE**
  - No write, no stall. Prevents the same instruction from re-triggering while it is held in MA.
  - Return to IDLE when `!i_pipe_stall_ext` or `i_flush`.
- **Ops (funct5):**
  - SWAP 00001 = rs2
  - ADD 00000: wraps modulo 2^XLEN
  - XOR 00100
  - AND 01100
  - OR 01000
  - MIN 10000 / MAX 10100: signed
  - MINU 11000 / MAXU 11100: unsigned
  - Any other code writes `old_q` back unchanged.
- **Reservation register:** valid bit plus word address.
  - LR.W sets it to `i_addr[XLEN-1:2]`.
  - `o_sc_success` = valid && address match && `i_sc_valid`.
  - Any SC, success or fail, clears the reservation in the same cycle.
  - A snoop that matches the reserved word clears it.
  - If LR and a matching snoop occur in the same cycle, LR wins.
  - Memory write and rd=0/1 for SC are handled by the normal store/writeback path.

## Timing
- AMO stalls for 2 cycles (IDLE-accept and READ); the write is issued 2 cycles after MA entry.
- `o_amo_read_phase` is asserted in READ, the cycle the forwarding unit refreshes MA data.
- **Reset values:** state IDLE; all outputs 0; `old_q`, `result_q` and the reservation cleared.
- Reset in any state aborts with no write.
- Back-to-back AMOs: the second is accepted in the IDLE that follows WRITE (or DONE); no cycle is lost when there is no external stall.

## Structure
- `riscv_pkg` gets `amo_state_e` (IDLE/READ/WRITE/DONE) and `amo_funct5_e` (the nine codes plus LR 00010 and SC 00011).
- Sub-module `amo_alu`: combinational (old, rs2, funct5) → result; holds the signed/unsigned compare logic. It is instantiated once and its output is registered in READ.

## Test plan
- **AMOADD:** mem[0x100]=0x7FFFFFFF, rs2=1 → stall 2 cycles; write 0x80000000; rd=0x7FFFFFFF; `read_phase` high exactly 1 cycle.
- **Signed vs unsigned:** AMOMIN vs AMOMINU with old=0xFFFFFFFE, rs2=3 → MIN writes 0xFFFFFFFE, MINU writes 3.
- **External stall:** `i_pipe_stall_ext` held 3 cycles during WRITE → single write pulse; DONE held; no second AMO.
- **LR/SC:**
  - LR 0x200 then SC 0x200 → success=1, reservation cleared.
  - LR 0x200, snoop 0x202, SC 0x200 → success=0.
- **Abort:** `i_flush` in READ → no write; state IDLE next cycle.
- **Reset:** `i_rst` in READ → no write; all outputs 0.
- **Back-to-back:** AMOSWAP followed immediately by AMOOR → two writes 3 cycles apart.
